// File: rtl/phase_sine_pkg.sv
// Package: phase_sine_pkg
// Purpose: shared constants and helpers for the phase-to-sine converter.
//   - quadrant encodings Q0..Q3 of the two phase MSBs
//   - amax()/a1(): full-scale amplitude and unity gain for a given sample width
//   - lut_depth(): number of quarter-wave table entries
//   - lut_entry(): real-to-fixed rounded table value
//   - fold_needed()/negate_needed(): quadrant symmetry rules
package phase_sine_pkg;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    // Largest positive sample: 2^(ow-1)-1.
    function automatic int amax(input int ow);
        return (1 << (ow - 1)) - 1;
    endfunction

    // Unity gain (and the amplitude clamp value): 2^(ow-1).
    function automatic int a1(input int ow);
        return 1 << (ow - 1);
    endfunction

    function automatic int lut_depth(input int aw);
        return 1 << aw;
    endfunction

    // Sampling at (i+0.5) keeps the table symmetric under address mirroring,
    // so no entry is 0 and the peak never reaches exactly pi/2.
    function automatic int lut_entry(input int i, input int aw, input int ow);
        real x;
        x = (3.14159265358979323846 / 2.0) * (real'(i) + 0.5) / real'(lut_depth(aw));
        return $rtoi(real'(amax(ow)) * $sin(x) + 0.5);
    endfunction

    // Quadrants 1 and 3 run the quarter wave backwards.
    function automatic logic fold_needed(input logic [1:0] q);
        logic f;
        case (q)
            Q0:      f = 1'b0;
            Q1:      f = 1'b1;
            Q2:      f = 1'b0;
            Q3:      f = 1'b1;
            default: f = 1'b0;
        endcase
        return f;
    endfunction

    // Quadrants 2 and 3 are the negative half cycle.
    function automatic logic negate_needed(input logic [1:0] q);
        logic n;
        case (q)
            Q0:      n = 1'b0;
            Q1:      n = 1'b0;
            Q2:      n = 1'b1;
            Q3:      n = 1'b1;
            default: n = 1'b0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/sine_quarter_rom.sv
// Module: sine_quarter_rom
// Purpose: quarter-wave sine table with a registered read. One read port by
//   default; a second independent read port when PHASE_SINE_COS_EN is defined.
// Ports:
//   clk_i     in   clock
//   rstn_i    in   asynchronous active-low reset (clears the output registers)
//   addr_a_i  in   LUT_AW   read address, port A
//   data_a_o  out  OUT_WIDTH  table value (unsigned magnitude), one cycle later
//   addr_b_i  in   LUT_AW   read address, port B (PHASE_SINE_COS_EN only)
//   data_b_o  out  OUT_WIDTH  port B value (PHASE_SINE_COS_EN only)
module sine_quarter_rom
    import phase_sine_pkg::*;
#(
    parameter int LUT_AW    = 10,
    parameter int OUT_WIDTH = 14
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic [LUT_AW-1:0]    addr_a_i,
    output logic [OUT_WIDTH-1:0] data_a_o
`ifdef PHASE_SINE_COS_EN
    ,
    input  logic [LUT_AW-1:0]    addr_b_i,
    output logic [OUT_WIDTH-1:0] data_b_o
`endif
);

    localparam int DEPTH = lut_depth(LUT_AW);

    // Constant table contents, elaborated from the package rounding function.
    logic [OUT_WIDTH-1:0] rom [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_rom
        assign rom[g] = OUT_WIDTH'(lut_entry(g, LUT_AW, OUT_WIDTH));
    end

    logic [OUT_WIDTH-1:0] data_a_d, data_a_q;

    always_comb begin
        data_a_d = rom[addr_a_i];
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            data_a_q <= '0;
        end else begin
            data_a_q <= data_a_d;
        end
    end

    assign data_a_o = data_a_q;

`ifdef PHASE_SINE_COS_EN
    logic [OUT_WIDTH-1:0] data_b_d, data_b_q;

    always_comb begin
        data_b_d = rom[addr_b_i];
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            data_b_q <= '0;
        end else begin
            data_b_q <= data_b_d;
        end
    end

    assign data_b_o = data_b_q;
`endif

endmodule

// File: rtl/phase_to_sine.sv
// Module: phase_to_sine
// Purpose: converts a wrapped unsigned phase word into a signed, gain-scaled
//   sine sample using a quarter-wave table with quadrant folding.
//   Fixed 4-stage pipeline:
//     S1 register phase fields and clamped gain
//     S2 fold index, registered table read
//     S3 conditional negate
//     S4 gain multiply and arithmetic rescale
//   Optional feature macro: PHASE_SINE_COS_EN adds cos_o with identical latency.
// Ports:
//   clk_i    in   clock
//   rstn_i   in   asynchronous active-low reset
//   phase_i  in   WIDTH      unsigned phase, full circle = 2^WIDTH
//   valid_i  in   qualifier for phase_i/amp_i
//   amp_i    in   OUT_WIDTH  unsigned gain, 2^(OUT_WIDTH-1) = unity
//   sin_o    out  OUT_WIDTH  signed scaled sine
//   valid_o  out  qualifier for sin_o (and cos_o)
//   cos_o    out  OUT_WIDTH  signed scaled cosine (PHASE_SINE_COS_EN only)
//
// Handshake: valid_i marks a sample on every cycle it is high; there is no
//   ready, every sample is accepted. valid_o follows valid_i exactly 4 cycles
//   later; data outputs are meaningless while valid_o is low.
module phase_to_sine
    import phase_sine_pkg::*;
#(
    parameter int WIDTH     = 14,
    parameter int OUT_WIDTH = 14,
    parameter int LUT_AW    = 10
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic [WIDTH-1:0]            phase_i,
    input  logic                        valid_i,
    input  logic [OUT_WIDTH-1:0]        amp_i,
    output logic signed [OUT_WIDTH-1:0] sin_o,
    output logic                        valid_o
`ifdef PHASE_SINE_COS_EN
    ,
    output logic signed [OUT_WIDTH-1:0] cos_o
`endif
);

    localparam int                   PW   = 2 * OUT_WIDTH + 1;
    localparam logic [OUT_WIDTH-1:0] A1_V = OUT_WIDTH'(a1(OUT_WIDTH));

    // Phase bits below the table index are intentionally dropped.
    logic unused_phase_bits;
    assign unused_phase_bits = ^phase_i;

    // S1
    logic [1:0]           q1_d, q1_q;
    logic [LUT_AW-1:0]    idx1_d, idx1_q;
    logic [OUT_WIDTH-1:0] amp1_d, amp1_q;
    logic                 valid1_d, valid1_q;
    // S2
    logic [LUT_AW-1:0]    addr_s;
    logic [OUT_WIDTH-1:0] rom_s;
    logic [1:0]           q2_d, q2_q;
    logic [OUT_WIDTH-1:0] amp2_d, amp2_q;
    logic                 valid2_d, valid2_q;
    // S3
    logic signed [OUT_WIDTH-1:0] s3_d, s3_q;
    logic [OUT_WIDTH-1:0]        amp3_d, amp3_q;
    logic                        valid3_d, valid3_q;
    // S4
    logic signed [PW-1:0]        prod_s;
    logic signed [OUT_WIDTH-1:0] sin4_d, sin4_q;
    logic                        valid4_d, valid4_q;

`ifdef PHASE_SINE_COS_EN
    logic [1:0]                  qc1_s;
    logic [LUT_AW-1:0]           addr_c;
    logic [OUT_WIDTH-1:0]        rom_c;
    logic [1:0]                  qc2_d, qc2_q;
    logic signed [OUT_WIDTH-1:0] c3_d, c3_q;
    logic signed [PW-1:0]        prod_c;
    logic signed [OUT_WIDTH-1:0] cos4_d, cos4_q;
`endif

    always_comb begin
        // S1: split phase, clamp gain to unity so |result| never exceeds AMAX.
        q1_d     = phase_i[WIDTH-1 -: 2];
        idx1_d   = phase_i[WIDTH-3 -: LUT_AW];
        amp1_d   = (amp_i > A1_V) ? A1_V : amp_i;
        valid1_d = valid_i;

        // S2
        addr_s   = fold_needed(q1_q) ? ~idx1_q : idx1_q;
        q2_d     = q1_q;
        amp2_d   = amp1_q;
        valid2_d = valid1_q;

        // S3: table values are positive and <= AMAX, so negation cannot overflow.
        s3_d     = negate_needed(q2_q) ? OUT_WIDTH'(OUT_WIDTH'(0) - rom_s) : rom_s;
        amp3_d   = amp2_q;
        valid3_d = valid2_q;

        // S4: signed x unsigned multiply; gain gets a zero MSB to stay positive.
        prod_s   = PW'(s3_q) * PW'($signed({1'b0, amp3_q}));
        sin4_d   = OUT_WIDTH'(prod_s >>> (OUT_WIDTH - 1));
        valid4_d = valid3_q;

`ifdef PHASE_SINE_COS_EN
        // Cosine is sine a quarter turn ahead: same index, next quadrant.
        qc1_s  = q1_q + 2'd1;
        addr_c = fold_needed(qc1_s) ? ~idx1_q : idx1_q;
        qc2_d  = qc1_s;
        c3_d   = negate_needed(qc2_q) ? OUT_WIDTH'(OUT_WIDTH'(0) - rom_c) : rom_c;
        prod_c = PW'(c3_q) * PW'($signed({1'b0, amp3_q}));
        cos4_d = OUT_WIDTH'(prod_c >>> (OUT_WIDTH - 1));
`endif
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            q1_q     <= '0;
            idx1_q   <= '0;
            amp1_q   <= '0;
            valid1_q <= 1'b0;
            q2_q     <= '0;
            amp2_q   <= '0;
            valid2_q <= 1'b0;
            s3_q     <= '0;
            amp3_q   <= '0;
            valid3_q <= 1'b0;
            sin4_q   <= '0;
            valid4_q <= 1'b0;
`ifdef PHASE_SINE_COS_EN
            qc2_q    <= '0;
            c3_q     <= '0;
            cos4_q   <= '0;
`endif
        end else begin
            q1_q     <= q1_d;
            idx1_q   <= idx1_d;
            amp1_q   <= amp1_d;
            valid1_q <= valid1_d;
            q2_q     <= q2_d;
            amp2_q   <= amp2_d;
            valid2_q <= valid2_d;
            s3_q     <= s3_d;
            amp3_q   <= amp3_d;
            valid3_q <= valid3_d;
            sin4_q   <= sin4_d;
            valid4_q <= valid4_d;
`ifdef PHASE_SINE_COS_EN
            qc2_q    <= qc2_d;
            c3_q     <= c3_d;
            cos4_q   <= cos4_d;
`endif
        end
    end

    sine_quarter_rom #(
        .LUT_AW   (LUT_AW),
        .OUT_WIDTH(OUT_WIDTH)
    ) u_rom (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .addr_a_i(addr_s),
        .data_a_o(rom_s)
`ifdef PHASE_SINE_COS_EN
        ,
        .addr_b_i(addr_c),
        .data_b_o(rom_c)
`endif
    );

    assign sin_o   = sin4_q;
    assign valid_o = valid4_q;
`ifdef PHASE_SINE_COS_EN
    assign cos_o   = cos4_q;
`endif

endmodule

// File: tb/tb_phase_to_sine.sv
// Testbench: tb_phase_to_sine
// Directed checks of phase_to_sine: reset, quadrant values and latency, gain
// and clamp, bubbles, mid-stream reset, and a full phase sweep with wrap.
// Expected samples are queued when driven and popped when valid_o is due.
// Build with PHASE_SINE_COS_EN to also check cos_o.
module tb_phase_to_sine;

    localparam int W   = 14;
    localparam int OW  = 14;
    localparam int LAT = 4;

    logic                 clk;
    logic                 rstn;
    logic [W-1:0]         phase_i;
    logic                 valid_i;
    logic [OW-1:0]        amp_i;
    logic signed [OW-1:0] sin_o;
    logic                 valid_o;
`ifdef PHASE_SINE_COS_EN
    logic signed [OW-1:0] cos_o;
`endif

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    logic [31:0] exp_cos_q[$];
    logic        vhist_q[$];

    phase_to_sine #(.WIDTH(W), .OUT_WIDTH(OW), .LUT_AW(10)) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .phase_i(phase_i),
        .valid_i(valid_i),
        .amp_i  (amp_i),
        .sin_o  (sin_o),
        .valid_o(valid_o)
`ifdef PHASE_SINE_COS_EN
        ,
        .cos_o  (cos_o)
`endif
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // Reference: quarter-wave table math written out from first principles.
    function automatic int golden(input int ph, input int amp);
        int  q;
        int  idx;
        int  addr;
        int  lut;
        int  s;
        int  a;
        longint p;
        real x;
        q    = (ph >> 12) & 3;
        idx  = (ph >> 2) & 1023;
        addr = (q == 1 || q == 3) ? (1023 - idx) : idx;
        x    = (3.14159265358979323846 / 2.0) * (real'(addr) + 0.5) / 1024.0;
        lut  = $rtoi(8191.0 * $sin(x) + 0.5);
        s    = (q >= 2) ? -lut : lut;
        a    = (amp > 8192) ? 8192 : amp;
        p    = longint'(s) * longint'(a);
        return int'(p >>> 13);
    endfunction

    function automatic logic [31:0] sext(input logic [OW-1:0] v);
        return {{(32-OW){v[OW-1]}}, v};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d", tag, $signed(obs), $signed(expv));
        end
    endtask

    // Drive one cycle, then compare whatever the DUT presents after the edge.
    task automatic drive(input logic v, input int ph, input int amp, input int exp_sin);
        logic ev;
        logic [31:0] es;
        logic [31:0] ec;
        valid_i = v;
        phase_i = W'(ph);
        amp_i   = OW'(amp);
        if (v) begin
            exp_q.push_back(32'(exp_sin));
            exp_cos_q.push_back(32'(golden((ph + 4096) % 16384, amp)));
        end
        vhist_q.push_back(v);
        @(posedge clk);
        #1;
        if (vhist_q.size() == LAT) begin
            ev = vhist_q.pop_front();
            check("valid_o", {31'd0, valid_o}, {31'd0, ev});
            if (ev) begin
                es = exp_q.pop_front();
                ec = exp_cos_q.pop_front();
                check("sin_o", sext(sin_o), es);
`ifdef PHASE_SINE_COS_EN
                check("cos_o", sext(cos_o), ec);
`endif
            end
        end else begin
            check("valid_o_fill", {31'd0, valid_o}, 32'd0);
        end
    endtask

    task automatic flush();
        repeat (LAT) drive(1'b0, 0, 0, 0);
    endtask

    task automatic clear_sb();
        exp_q.delete();
        exp_cos_q.delete();
        vhist_q.delete();
    endtask

    initial begin
        int ph;
        int amp;
        // Reset held with valid_i high: outputs must stay cleared.
        rstn    = 1'b0;
        valid_i = 1'b1;
        phase_i = W'(4096);
        amp_i   = OW'(8192);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("rst_valid_o", {31'd0, valid_o}, 32'd0);
            check("rst_sin_o", sext(sin_o), 32'd0);
        end
        @(negedge clk);
        rstn = 1'b1;
        clear_sb();

        // Quadrant points and latency (constants from hand calculation).
        drive(1'b1, 0,     8192, 6);
        drive(1'b1, 4096,  8192, 8191);
        drive(1'b1, 8192,  8192, -6);
        drive(1'b1, 12288, 8192, -8191);
        flush();

        // Gain, clamp and zero gain.
        drive(1'b1, 4096, 4096,  4095);
        drive(1'b1, 4096, 16383, 8191);
        drive(1'b1, 4096, 0,     0);
        flush();

        // Bubble pattern 1,0,1,1,0.
        for (int i = 0; i < 5; i++) begin
            logic v;
            v   = (i == 1 || i == 4) ? 1'b0 : 1'b1;
            ph  = int'($urandom_range(0, 16383));
            amp = int'($urandom_range(0, 16383));
            drive(v, ph, amp, golden(ph, amp));
        end
        flush();

        // Mid-stream reset during a ramp.
        for (int i = 0; i < 10; i++) drive(1'b1, 1000 + i * 37, 8192, golden(1000 + i * 37, 8192));
        #3;
        rstn = 1'b0;
        #1;
        check("mrst_valid_async", {31'd0, valid_o}, 32'd0);
        check("mrst_sin_async", sext(sin_o), 32'd0);
        clear_sb();
        @(posedge clk);
        #1;
        check("mrst_valid_hold", {31'd0, valid_o}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 10; i++) drive(1'b1, 5000 + i * 91, 6000, golden(5000 + i * 91, 6000));
        flush();

        // Full sweep with wrap back through 0.
        for (int p = 0; p < 16384 + 16; p++) begin
            drive(1'b1, p % 16384, 8192, golden(p % 16384, 8192));
        end
        flush();

        // Random gains over random phases.
        for (int i = 0; i < 40; i++) begin
            ph  = int'($urandom_range(0, 16383));
            amp = int'($urandom_range(0, 16383));
            drive(1'b1, ph, amp, golden(ph, amp));
        end
        flush();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
